// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_e;

  // Integer clock cycles per serial bit; the caller must keep the result >= 2.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq_hz,
                                               input int unsigned baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, wraps on its own, and flags the
// last cycle of each bit period.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_i,
  input  logic restart,
  output logic bit_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign bit_done = (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      count <= '0;
    end else if (restart || bit_done) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from an upstream FIFO and shifts them out
// LSB first with one start and one stop bit; all line outputs are registered.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] fifo_q_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_deq_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_e                state, state_next;
  logic [IDX_W-1:0]      bit_idx, bit_idx_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  armed;
  logic                  bit_done;
  logic                  timer_restart;

  // Timer is held at zero outside the serial states, so every entry into START begins a full bit.
  assign timer_restart = (state == IDLE) || (state == LOAD);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset_i (reset_i),
    .restart (timer_restart),
    .bit_done(bit_done)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    case (state)
      IDLE: begin
        if (armed && enable_i && !fifo_empty_i) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = START;
      end
      START: begin
        if (bit_done) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == LAST_IDX) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      bit_idx    <= '0;
      // NOTE: the data register is reset too; it is a single word, not a memory array, so the reset is cheap.
      shift_reg  <= '0;
      armed      <= 1'b0;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
      fifo_deq_o <= 1'b0;
    end else begin
      state   <= state_next;
      bit_idx <= bit_idx_next;
      // Holds off the first LOAD until the second edge after reset release.
      armed   <= 1'b1;
      if (state == LOAD) begin
        shift_reg <= fifo_q_i;
      end
      fifo_deq_o <= (state_next == LOAD);
      busy_o     <= (state_next != IDLE);
      case (state_next)
        START:   tx_o <= 1'b0;
        DATA:    tx_o <= shift_reg[bit_idx_next];
        default: tx_o <= 1'b1;
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer divide), SHALL be >= 2.
REQ-003 Parameter DATA_WIDTH, default 8, bits per frame, LSB first.
REQ-004 clk  input  1  single clock for all logic; rising-edge.
REQ-005 reset_i  input  1  reset, asynchronous and active-high.
REQ-006 enable_i  input  1  1 = new frames may start; 0 = hold in IDLE after any frame in progress.
REQ-007 fifo_q_i  input  DATA_WIDTH  head word from upstream FIFO read port.
REQ-008 fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-009 fifo_deq_o  output  1  one-cycle dequeue strobe to upstream FIFO.
REQ-010 tx_o  output  1  serial line, idle high.
REQ-011 busy_o  output  1  high while a frame is being loaded or shifted.

Function
REQ-012 State machine states SHALL be IDLE, LOAD, START, DATA, STOP.
REQ-013 IDLE: tx_o=1, busy_o=0, fifo_deq_o=0; if enable_i=1 and fifo_empty_i=0, next state LOAD.
REQ-014 LOAD (exactly 1 cycle): latch fifo_q_i into shift register, assert fifo_deq_o=1, busy_o=1, tx_o=1; next state START.
REQ-015 fifo_q_i SHALL be sampled only in LOAD, at least one cycle after the previous fifo_deq_o pulse, so the FIFO's registered read address has settled.
REQ-016 fifo_deq_o SHALL never be asserted outside LOAD and never while fifo_empty_i=1.
REQ-017 START: tx_o=0 for CLKS_PER_BIT cycles; next DATA with bit index 0.
REQ-018 DATA: tx_o = shift register bit[index] for CLKS_PER_BIT cycles each, index 0..DATA_WIDTH-1; after last bit next STOP.
REQ-019 STOP: tx_o=1 for CLKS_PER_BIT cycles; next IDLE.
REQ-020 Bit timer counts 0..CLKS_PER_BIT-1 and reloads at 0 on every state entry into START/DATA/STOP; width $clog2(CLKS_PER_BIT).
REQ-021 Frame length SHALL be exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles from first START cycle to last STOP cycle.
REQ-022 Back-to-back: with FIFO non-empty and enable_i=1, gap between last STOP cycle and next START cycle SHALL be exactly 2 cycles (IDLE, LOAD) with tx_o=1.
REQ-023 enable_i deasserted mid-frame: current frame SHALL complete unchanged; no new LOAD.
REQ-024 fifo_empty_i changes during START/DATA/STOP SHALL have no effect until IDLE.

Reset
REQ-025 On reset_i=1, asynchronously: state=IDLE, tx_o=1, busy_o=0, fifo_deq_o=0, bit timer=0, bit index=0, shift register=0.
REQ-026 Reset mid-frame SHALL abort the frame immediately (tx_o high); a word already dequeued is discarded.
REQ-027 After reset_i deasserts, first LOAD SHALL occur no earlier than the second rising edge.

Structure
REQ-028 Package fifo_uart_tx_pkg SHALL hold the state enum type and a function computing CLKS_PER_BIT.
REQ-029 Outputs tx_o, busy_o, fifo_deq_o SHALL be registered (glitch-free line).
REQ-030 One sub-module, uart_bit_timer, SHALL implement the bit timer with restart input and end-of-bit pulse output.

Verification (CLK_FREQ_HZ=1_000_000, BAUD_RATE=250_000 => CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-031 FIFO holds 0xA5, enable_i=1 -> one deq pulse; tx_o = 0,1,0,1,0,0,1,0,1,1 each 4 cycles (40 cycles); busy_o high 41 cycles.
REQ-032 FIFO holds 0x00,0xFF -> two frames, exactly 2 idle-high cycles between; exactly 2 deq pulses.
REQ-033 FIFO empty, enable_i=1 for 100 cycles -> tx_o=1, busy_o=0, fifo_deq_o=0 throughout.
REQ-034 enable_i dropped at bit 3 of 0x3C with 0x55 queued -> 0x3C completes; 0x55 not dequeued until enable_i=1.
REQ-035 reset_i pulsed at DATA bit 5 -> tx_o=1 same cycle without clock edge; state IDLE; next queued word sent intact.
REQ-036 Scoreboard: fifo_uart_tx driven by a FIFO with 64 random words -> decoded serial stream equals enqueued order, no dequeue while empty.
